// File: rtl/floo_wrr_lock_arbiter.sv
// Weighted round-robin arbiter with an optional wormhole lock.
// An input that keeps requesting may complete up to max(weight,1) packets in
// a row before priority moves past it. With LockEn, a granted multi-flit
// packet keeps the grant until its tail flit transfers. Grant is combinational.
module floo_wrr_lock_arbiter #(
  parameter int unsigned NumInputs      = 4,
  parameter int unsigned WeightWidth    = 3,
  parameter bit          LockEn         = 1'b1,
  localparam int unsigned NumInputsWidth = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumInputs-1:0]             req_i,
  input  logic [NumInputs-1:0]             last_i,
  input  logic [NumInputs*WeightWidth-1:0] weight_i,
  input  logic                             ready_i,
  output logic                             valid_o,
  output logic [NumInputs-1:0]             grant_o,
  output logic [NumInputsWidth-1:0]        grant_id_o
);

  logic [NumInputsWidth-1:0] ptr_q, ptr_d;
  logic [WeightWidth-1:0]    cnt_q, cnt_d;
  logic                      lock_q, lock_d;
  logic [NumInputsWidth-1:0] lock_id_q, lock_id_d;

  logic                      scan_found;
  logic [NumInputsWidth-1:0] scan_id;
  logic                      xfer;
  logic [WeightWidth-1:0]    weight_arr [NumInputs];
  logic [WeightWidth-1:0]    w_sel;
  logic [WeightWidth:0]      w_eff;
  logic [WeightWidth:0]      n_done;
  logic [NumInputsWidth-1:0] ptr_after;

  // Unpack the flat weight bus into one field per input
  for (genvar gi = 0; gi < NumInputs; gi++) begin : g_weight
    assign weight_arr[gi] = weight_i[gi*WeightWidth +: WeightWidth];
  end

  // First requesting input scanning from ptr_q upward, wrapping modulo NumInputs
  always_comb begin : p_scan
    int unsigned idx;
    scan_found = 1'b0;
    scan_id    = '0;
    idx        = 0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NumInputs) idx = idx - NumInputs;
      if (!scan_found && req_i[NumInputsWidth'(idx)]) begin
        scan_found = 1'b1;
        scan_id    = NumInputsWidth'(idx);
      end
    end
  end

  // Grant outputs: a held lock masks every other requester
  always_comb begin
    if (lock_q) begin
      valid_o    = req_i[lock_id_q];
      grant_id_o = lock_id_q;
    end else begin
      valid_o    = scan_found;
      grant_id_o = scan_id;
    end
    grant_o = valid_o ? (NumInputs'(1) << grant_id_o) : '0;
  end

  assign xfer = valid_o & ready_i;

  // Next state: lock on a non-tail flit, otherwise account a finished packet
  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    w_sel     = weight_arr[grant_id_o];
    // a zero weight still allows one packet per turn
    w_eff     = (w_sel == '0) ? (WeightWidth+1)'(1) : {1'b0, w_sel};
    // a grant away from ptr_q means the owner was idle: a fresh turn starts
    n_done    = (grant_id_o == ptr_q) ? ({1'b0, cnt_q} + (WeightWidth+1)'(1))
                                      : (WeightWidth+1)'(1);
    ptr_after = (grant_id_o == NumInputsWidth'(NumInputs - 1)) ? '0
                                                               : grant_id_o + NumInputsWidth'(1);
    if (xfer) begin
      if (LockEn && !last_i[grant_id_o]) begin
        lock_d    = 1'b1;
        lock_id_d = grant_id_o;
      end else begin
        lock_d = 1'b0;
        if (n_done >= w_eff) begin
          ptr_d = ptr_after;
          cnt_d = '0;
        end else begin
          ptr_d = grant_id_o;
          // n_done < w_eff <= 2^WeightWidth-1, so the truncation is lossless
          cnt_d = n_done[WeightWidth-1:0];
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      cnt_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

endmodule

// File: tb/tb_floo_wrr_lock_arbiter.sv
// Directed bench for floo_wrr_lock_arbiter: a 4-input locking instance and a
// 3-input instance for the non-power-of-two wrap.
module tb_floo_wrr_lock_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, last;
  logic [11:0] weight;
  logic        ready;
  logic        valid;
  logic [3:0]  grant;
  logic [1:0]  grant_id;

  logic [2:0]  req3, last3;
  logic [8:0]  weight3;
  logic        ready3;
  logic        valid3;
  logic [2:0]  grant3;
  logic [1:0]  grant_id3;

  int n_checks = 0;
  int n_errors = 0;

  int exp_rot [5]  = '{0, 1, 2, 3, 0};
  int exp_wgt [10] = '{0, 1, 1, 1, 2, 3, 0, 1, 1, 1};
  int exp_n3  [5]  = '{0, 1, 2, 0, 1};

  always #5 clk = ~clk;

  floo_wrr_lock_arbiter #(.NumInputs(4), .WeightWidth(3), .LockEn(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .last_i(last), .weight_i(weight),
    .ready_i(ready), .valid_o(valid), .grant_o(grant), .grant_id_o(grant_id)
  );

  floo_wrr_lock_arbiter #(.NumInputs(3), .WeightWidth(3), .LockEn(1'b1)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req3), .last_i(last3), .weight_i(weight3),
    .ready_i(ready3), .valid_o(valid3), .grant_o(grant3), .grant_id_o(grant_id3)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; last = '0; ready = 1'b0;
    req3 = '0; last3 = '0; ready3 = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    weight  = {3'd1, 3'd1, 3'd1, 3'd1};
    weight3 = {3'd1, 3'd1, 3'd1};
    do_reset();
    rst_n = 1'b0;
    #1;
    // reset state with no requests
    check_eq("reset_valid", int'(valid), 0);
    check_eq("reset_grant", int'(grant), 0);
    check_eq("reset_id", int'(grant_id), 0);
    check_eq("reset_ptr", int'(dut.ptr_q), 0);
    rst_n = 1'b1;
    #1;

    // basic rotation, all weights 1
    req = 4'b1111; last = 4'b1111; ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("rot_id[%0d]", k), int'(grant_id), exp_rot[k]);
      cycle();
    end
    check_eq("rot_grant_onehot", int'(grant), 4'b0010);

    // weighting {1,3,1,1}
    do_reset();
    weight = {3'd1, 3'd1, 3'd3, 3'd1};
    req = 4'b1111; last = 4'b1111; ready = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("wgt_id[%0d]", k), int'(grant_id), exp_wgt[k]);
      cycle();
    end

    // wormhole lock: input 0 sends 3 flits, req[0] drops mid-packet
    do_reset();
    weight = {3'd1, 3'd1, 3'd1, 3'd1};
    req = 4'b0011; last = 4'b0000; ready = 1'b1;
    #1;
    check_eq("lock_f1_id", int'(grant_id), 0);
    cycle();
    check_eq("lock_set", int'(dut.lock_q), 1);
    check_eq("lock_f2_id", int'(grant_id), 0);
    cycle();
    req = 4'b0010; last = 4'b0010;
    #1;
    check_eq("lock_drop_valid", int'(valid), 0);
    check_eq("lock_drop_grant", int'(grant), 0);
    check_eq("lock_drop_id", int'(grant_id), 0);
    cycle();
    check_eq("lock_held", int'(dut.lock_q), 1);
    req = 4'b0011; last = 4'b0011;
    #1;
    check_eq("lock_f3_grant", int'(grant), 4'b0001);
    cycle();
    check_eq("lock_released", int'(dut.lock_q), 0);
    check_eq("lock_next_id", int'(grant_id), 1);

    // backpressure with req=0110 from ptr 0
    do_reset();
    req = 4'b0110; last = 4'b1111; ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("bp_id[%0d]", k), int'(grant_id), 1);
      cycle();
    end
    check_eq("bp_ptr", int'(dut.ptr_q), 0);
    check_eq("bp_cnt", int'(dut.cnt_q), 0);
    ready = 1'b1;
    #1;
    check_eq("bp_xfer_id", int'(grant_id), 1);
    cycle();
    check_eq("bp_after_id", int'(grant_id), 2);

    // idle owner and zero weight: weights {0,2,0,0}
    do_reset();
    weight = {3'd0, 3'd0, 3'd2, 3'd0};
    req = 4'b0001; last = 4'b1111; ready = 1'b1;
    cycle();
    check_eq("idle_ptr_setup", int'(dut.ptr_q), 1);
    check_eq("idle_grant", int'(grant), 4'b0001);
    cycle();
    check_eq("idle_ptr", int'(dut.ptr_q), 1);
    check_eq("idle_cnt", int'(dut.cnt_q), 0);
    req = 4'b0010;
    cycle();
    check_eq("w2_cnt", int'(dut.cnt_q), 1);
    check_eq("w2_ptr_hold", int'(dut.ptr_q), 1);
    cycle();
    check_eq("w2_ptr_rot", int'(dut.ptr_q), 2);
    check_eq("w2_cnt_clr", int'(dut.cnt_q), 0);

    // three inputs: wrap 2 -> 0
    do_reset();
    req3 = 3'b111; last3 = 3'b111; ready3 = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("n3_id[%0d]", k), int'(grant_id3), exp_n3[k]);
      cycle();
    end
    req3 = 3'b000;

    // asynchronous reset while locked on input 2
    do_reset();
    weight = {3'd1, 3'd1, 3'd1, 3'd1};
    req = 4'b0100; last = 4'b0000; ready = 1'b1;
    cycle();
    check_eq("arst_lock_set", int'(dut.lock_q), 1);
    check_eq("arst_lock_id", int'(dut.lock_id_q), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_lock_clr", int'(dut.lock_q), 0);
    check_eq("arst_ptr_clr", int'(dut.ptr_q), 0);
    rst_n = 1'b1;
    req = 4'b1111;
    #1;
    check_eq("arst_after_id", int'(grant_id), 0);
    check_eq("arst_after_valid", int'(valid), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
